// File: rtl/cpu_io_ctrl.sv
// cpu_io_ctrl: byte-I/O controller between the CPU pipeline and the UART cores.
//
// TX path: a CPU write request latches one byte and offers it to the UART TX on a
// valid/ready handshake; w_busy tells the CPU not to issue another request.
// RX path: received bytes go into a circular FIFO; the head byte is presented as
// r_data, irr flags pending data, and a CPU ack pops the head.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   cpu_w_req, cpu_w_data   write request pulse and byte to transmit
//   cpu_ack                 pop pulse for the RX FIFO head (also clears rx_overrun)
//   cpu_intr_en             interrupt enable
//   w_busy                  TX in progress
//   r_data, irr, intr_req   FIFO head byte, pending flag, gated interrupt
//   rx_count, rx_overrun    FIFO occupancy, sticky dropped-byte flag
//   tx_valid/tx_data/tx_ready  UART TX handshake
//   rx_valid/rx_data        UART RX byte strobe
module cpu_io_ctrl #(
   parameter int unsigned RX_DEPTH = 4,
   localparam int unsigned CW = $clog2(RX_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_w_req,
   input  logic [7:0]    cpu_w_data,
   input  logic          cpu_ack,
   input  logic          cpu_intr_en,
   output logic          w_busy,
   output logic [7:0]    r_data,
   output logic          irr,
   output logic          intr_req,
   output logic [CW-1:0] rx_count,
   output logic          rx_overrun,
   output logic          tx_valid,
   output logic [7:0]    tx_data,
   input  logic          tx_ready,
   input  logic          rx_valid,
   input  logic [7:0]    rx_data
);

   localparam int unsigned AW = $clog2(RX_DEPTH);

   // ---------------------------------------------------------------- TX path
   typedef enum logic [0:0] {StIdle, StSend} tx_state_e;

   tx_state_e  state_q, state_d;
   logic [7:0] tx_data_q, tx_data_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         tx_data_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         tx_data_q <= tx_data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      unique case (state_q)
         StIdle: begin
            if (cpu_w_req) begin
               tx_data_d = cpu_w_data;
               state_d   = StSend;
            end
         end
         StSend: begin
            // Requests arriving here are ignored; the held byte stays stable.
            if (tx_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign w_busy   = (state_q == StSend);
   assign tx_valid = w_busy;
   assign tx_data  = tx_data_q;

   // ---------------------------------------------------------------- RX path
   logic [7:0]    mem_q [RX_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    head_q, head_d;
   logic          irr_q, ovr_q, ovr_d;
   logic          empty, full, pop, push, drop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(RX_DEPTH));
   assign pop   = cpu_ack & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push  = rx_valid & (~full | pop);
   assign drop  = rx_valid & full & ~pop;

   always_comb begin
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      ovr_d    = drop ? 1'b1 : (cpu_ack ? 1'b0 : ovr_q);
      // New head is the incoming byte when it lands in the head slot this cycle.
      if (count_d == '0) begin
         head_d = 8'h00;
      end else if (push && (rd_ptr_d == wr_ptr_q)) begin
         head_d = rx_data;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) mem_q[wr_ptr_q] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= 8'h00;
         irr_q    <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         irr_q    <= (count_d != '0);
         ovr_q    <= ovr_d;
      end
   end

   assign r_data     = head_q;
   assign irr        = irr_q;
   assign intr_req   = irr_q & cpu_intr_en;
   assign rx_count   = count_q;
   assign rx_overrun = ovr_q;

endmodule

// File: tb/tb_cpu_io_ctrl.sv
// Bench for cpu_io_ctrl: a queue-based reference model updated on each rising
// edge, a falling-edge compare process, and directed literal checks.
module tb_cpu_io_ctrl;

   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n, cpu_w_req, cpu_ack, cpu_intr_en, tx_ready, rx_valid;
   logic [7:0] cpu_w_data, rx_data;
   logic       w_busy, irr, intr_req, rx_overrun, tx_valid;
   logic [7:0] r_data, tx_data;
   logic [2:0] rx_count;

   int total = 0;
   int bad   = 0;
   bit started = 0;

   cpu_io_ctrl #(.RX_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_w_req  (cpu_w_req),
      .cpu_w_data (cpu_w_data),
      .cpu_ack    (cpu_ack),
      .cpu_intr_en(cpu_intr_en),
      .w_busy     (w_busy),
      .r_data     (r_data),
      .irr        (irr),
      .intr_req   (intr_req),
      .rx_count   (rx_count),
      .rx_overrun (rx_overrun),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: TX as a busy flag plus held byte, RX as a byte queue.
   bit         m_busy  = 0;
   bit         m_fresh = 1;
   logic [7:0] m_txd   = 8'h00;
   bit         m_ovr   = 0;
   logic [7:0] mq[$];

   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy  = 0;
         m_fresh = 1;
         m_txd   = 8'h00;
         m_ovr   = 0;
         mq.delete();
      end else begin
         if (m_busy) begin
            if (tx_ready) m_busy = 0;
         end else if (cpu_w_req) begin
            m_busy  = 1;
            m_fresh = 0;
            m_txd   = cpu_w_data;
         end
         if (cpu_ack) begin
            m_ovr = 0;
            if (mq.size() > 0) void'(mq.pop_front());
         end
         if (rx_valid) begin
            if (mq.size() < DEPTH) mq.push_back(rx_data);
            else m_ovr = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("w_busy", 32'(w_busy), 32'(m_busy));
         chk("tx_valid", 32'(tx_valid), 32'(m_busy));
         if (m_busy || m_fresh) chk("tx_data", 32'(tx_data), 32'(m_txd));
         chk("r_data", 32'(r_data), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
         chk("irr", 32'(irr), 32'(mq.size() > 0));
         chk("intr_req", 32'(intr_req), 32'((mq.size() > 0) && cpu_intr_en));
         chk("rx_count", 32'(rx_count), 32'(mq.size()));
         chk("rx_overrun", 32'(rx_overrun), 32'(m_ovr));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_rx(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      cyc();
      rx_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_seq [4];
      rst_n = 1'b0; cpu_w_req = 1'b0; cpu_w_data = 8'h00; cpu_ack = 1'b0;
      cpu_intr_en = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      cyc();
      started = 1;
      cyc();
      chk("reset_count", 32'(rx_count), 32'h0);
      chk("reset_busy", 32'(w_busy), 32'h0);
      rst_n = 1'b1;
      cyc();

      // Single write with tx_ready already high.
      cpu_w_req = 1'b1; cpu_w_data = 8'h41;
      cyc();
      cpu_w_req = 1'b0; tx_ready = 1'b1;
      chk("t1_valid", 32'(tx_valid), 32'h1);
      chk("t1_data", 32'(tx_data), 32'h41);
      cyc();
      tx_ready = 1'b0;
      chk("t1_busy_low", 32'(w_busy), 32'h0);
      cyc();

      // Stalled write; a second request during SEND must be ignored.
      cpu_w_req = 1'b1; cpu_w_data = 8'h55;
      cyc();
      cpu_w_req = 1'b0;
      cyc();
      cpu_w_req = 1'b1; cpu_w_data = 8'hAA;
      cyc();
      cpu_w_req = 1'b0;
      chk("t2_hold", 32'(tx_data), 32'h55);
      repeat (3) cyc();
      chk("t2_still_busy", 32'(w_busy), 32'h1);
      tx_ready = 1'b1;
      cyc();
      tx_ready = 1'b0;
      chk("t2_done", 32'(w_busy), 32'h0);
      cyc();

      // Three bytes in, three acks out, interrupt gating.
      cpu_intr_en = 1'b1;
      push_rx(8'h10); push_rx(8'h20); push_rx(8'h30);
      chk("t3_count", 32'(rx_count), 32'h3);
      chk("t3_head", 32'(r_data), 32'h10);
      chk("t3_intr", 32'(intr_req), 32'h1);
      cpu_ack = 1'b1;
      cyc();
      chk("t3_head2", 32'(r_data), 32'h20);
      cpu_intr_en = 1'b0;
      cyc();
      chk("t3_head3", 32'(r_data), 32'h30);
      chk("t3_intr_off", 32'(intr_req), 32'h0);
      chk("t3_irr", 32'(irr), 32'h1);
      cyc();
      cpu_ack = 1'b0;
      chk("t3_irr_low", 32'(irr), 32'h0);
      chk("t3_empty_data", 32'(r_data), 32'h0);

      // Overflow: 5 bytes into a 4-deep FIFO.
      for (int i = 1; i <= 5; i++) push_rx(8'(i));
      chk("t4_count", 32'(rx_count), 32'h4);
      chk("t4_ovr", 32'(rx_overrun), 32'h1);
      chk("t4_head", 32'(r_data), 32'h01);
      cpu_ack = 1'b1;
      cyc();
      cpu_ack = 1'b0;
      chk("t4_ovr_clr", 32'(rx_overrun), 32'h0);
      chk("t4_head2", 32'(r_data), 32'h02);

      // Full FIFO with simultaneous push and pop, then drain through the wrap.
      push_rx(8'h06);
      rx_valid = 1'b1; rx_data = 8'h99; cpu_ack = 1'b1;
      cyc();
      rx_valid = 1'b0; cpu_ack = 1'b0;
      chk("t5_count", 32'(rx_count), 32'h4);
      chk("t5_no_ovr", 32'(rx_overrun), 32'h0);
      exp_seq[0] = 8'h03; exp_seq[1] = 8'h04; exp_seq[2] = 8'h06; exp_seq[3] = 8'h99;
      for (int i = 0; i < 4; i++) begin
         chk("t5_drain", 32'(r_data), 32'(exp_seq[i]));
         cpu_ack = 1'b1;
         cyc();
         cpu_ack = 1'b0;
      end
      chk("t5_empty", 32'(rx_count), 32'h0);
      // Ack and push together on an empty FIFO: push only.
      rx_valid = 1'b1; rx_data = 8'h5A; cpu_ack = 1'b1;
      cyc();
      rx_valid = 1'b0; cpu_ack = 1'b0;
      chk("t5_empty_both", 32'(rx_count), 32'h1);
      chk("t5_empty_head", 32'(r_data), 32'h5A);
      cpu_ack = 1'b1;
      cyc();
      cpu_ack = 1'b0;

      // Reset mid-transmission with bytes queued.
      cpu_intr_en = 1'b1;
      cpu_w_req = 1'b1; cpu_w_data = 8'h77;
      push_rx(8'hA1);
      cpu_w_req = 1'b0;
      push_rx(8'hA2);
      chk("t6_busy", 32'(w_busy), 32'h1);
      chk("t6_count", 32'(rx_count), 32'h2);
      rst_n = 1'b0;
      cyc();
      chk("t6_outs", {w_busy, tx_valid, tx_data, irr, intr_req, rx_count, rx_overrun, r_data},
          32'h0);
      rst_n = 1'b1;
      tx_ready = 1'b1;
      cpu_w_req = 1'b1; cpu_w_data = 8'h3C;
      cyc();
      cpu_w_req = 1'b0;
      chk("t6_fresh_data", 32'(tx_data), 32'h3C);
      chk("t6_fresh_valid", 32'(tx_valid), 32'h1);
      cyc();
      tx_ready = 1'b0;
      chk("t6_fresh_done", 32'(w_busy), 32'h0);
      repeat (2) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
